// File: rtl/memory_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: memory mode encoding, arbiter state and read owner.
// The mode enum mirrors MemoryModesPackage so command fields pass straight through to Memory.
package memory_port_arbiter_pkg;

    typedef enum logic [2:0] {
        ReadWriteMode_NONE = 3'd0,
        WORD               = 3'd1,
        HALFWORD           = 3'd2,
        BYTE               = 3'd3,
        WORDLEFT           = 3'd4,
        WORDRIGHT          = 3'd5
    } ReadWriteMode_t;

    typedef enum logic [1:0] {
        ARB_PREF_CPU   = 2'd0,
        ARB_PREF_DBG   = 2'd1,
        ARB_DBG_LOCKED = 2'd2
    } ArbState_t;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_DBG = 1'b1
    } MemOwner_t;

    typedef struct packed {
        logic      valid;
        MemOwner_t owner;
    } rd_tag_t;

    localparam rd_tag_t TAG_IDLE = '{valid: 1'b0, owner: OWNER_CPU};

    function automatic logic is_read(input ReadWriteMode_t mode);
        return mode != ReadWriteMode_NONE;
    endfunction

endpackage

// File: rtl/memory_port_arbiter_if.sv
// Requester and Memory-side bus of the memory port arbiter.
// dbg_lock exists only when MEM_ARB_LOCK_EN is defined.
interface memory_port_arbiter_if
    import memory_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic                cpu_req;
    logic [ADDR_W-1:0]   cpu_address;
    logic [DATA_W-1:0]   cpu_data;
    ReadWriteMode_t      cpu_writeMode;
    ReadWriteMode_t      cpu_readMode;
    logic                cpu_unsignedLoad;
    logic                cpu_grant;
    logic                cpu_rvalid;
    logic [DATA_W-1:0]   cpu_rdata;

    logic                dbg_req;
    logic [ADDR_W-1:0]   dbg_address;
    logic [DATA_W-1:0]   dbg_data;
    ReadWriteMode_t      dbg_writeMode;
    ReadWriteMode_t      dbg_readMode;
    logic                dbg_unsignedLoad;
    logic                dbg_grant;
    logic                dbg_rvalid;
    logic [DATA_W-1:0]   dbg_rdata;
`ifdef MEM_ARB_LOCK_EN
    logic                dbg_lock;
`endif

    logic [ADDR_W-1:0]   mem_address;
    logic [DATA_W-1:0]   mem_data;
    ReadWriteMode_t      mem_writeMode;
    ReadWriteMode_t      mem_readMode;
    logic                mem_unsignedLoad;
    logic [DATA_W-1:0]   mem_dataOutput;

    // Arbiter side.
    modport slave (
`ifdef MEM_ARB_LOCK_EN
        input  dbg_lock,
`endif
        input  cpu_req, cpu_address, cpu_data, cpu_writeMode, cpu_readMode, cpu_unsignedLoad,
        output cpu_grant, cpu_rvalid, cpu_rdata,
        input  dbg_req, dbg_address, dbg_data, dbg_writeMode, dbg_readMode, dbg_unsignedLoad,
        output dbg_grant, dbg_rvalid, dbg_rdata,
        output mem_address, mem_data, mem_writeMode, mem_readMode, mem_unsignedLoad,
        input  mem_dataOutput
    );

    // Requesters and Memory side.
    modport master (
`ifdef MEM_ARB_LOCK_EN
        output dbg_lock,
`endif
        output cpu_req, cpu_address, cpu_data, cpu_writeMode, cpu_readMode, cpu_unsignedLoad,
        input  cpu_grant, cpu_rvalid, cpu_rdata,
        output dbg_req, dbg_address, dbg_data, dbg_writeMode, dbg_readMode, dbg_unsignedLoad,
        input  dbg_grant, dbg_rvalid, dbg_rdata,
        input  mem_address, mem_data, mem_writeMode, mem_readMode, mem_unsignedLoad,
        output mem_dataOutput
    );

endinterface

// File: rtl/memory_port_arbiter_tracker.sv
// Two-stage read tag pipeline matching Memory's fixed read latency; the exiting tag
// selects which requester sees rvalid and the returned data.
module memory_read_tracker
    import memory_port_arbiter_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push_valid_i,
    input  MemOwner_t push_owner_i,
    output logic      cpu_rvalid_o,
    output logic      dbg_rvalid_o,
    output MemOwner_t rdata_sel_o
);

    rd_tag_t stage0_q, stage0_d;
    rd_tag_t stage1_q, stage1_d;

    // Shift next-state.
    always_comb begin
        stage0_d = TAG_IDLE;
        stage1_d = stage0_q;
        stage0_d.valid = push_valid_i;
        stage0_d.owner = push_owner_i;
    end

    // Tag registers, cleared synchronously so in-flight reads are dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stage0_q <= TAG_IDLE;
            stage1_q <= TAG_IDLE;
        end else begin
            stage0_q <= stage0_d;
            stage1_q <= stage1_d;
        end
    end

    assign cpu_rvalid_o = stage1_q.valid && (stage1_q.owner == OWNER_CPU);
    assign dbg_rvalid_o = stage1_q.valid && (stage1_q.owner == OWNER_DBG);
    assign rdata_sel_o  = stage1_q.owner;

endmodule

// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter sharing Memory's data port between the CPU and debug requesters.
// Define MEM_ARB_LOCK_EN to add dbg_lock and the debug-locked state.
module memory_port_arbiter
    import memory_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic                  clk,
    input logic                  rst,
    memory_port_arbiter_if.slave bus
);

    ArbState_t         state_q, state_d;
    ArbState_t         dbg_next_s;
    logic              cpu_grant_s, dbg_grant_s, any_grant_s;

    logic [ADDR_W-1:0] sel_address_s;
    logic [DATA_W-1:0] sel_data_s;
    ReadWriteMode_t    sel_write_s, sel_read_s;
    logic              sel_unsigned_s;
    MemOwner_t         sel_owner_s;

    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    ReadWriteMode_t    mem_write_q, mem_write_d;
    ReadWriteMode_t    mem_read_q, mem_read_d;
    logic              mem_unsigned_q, mem_unsigned_d;

    logic              cpu_rvalid_s, dbg_rvalid_s;
    MemOwner_t         rdata_sel_s;

    // State reached after a debug grant.
    always_comb begin
`ifdef MEM_ARB_LOCK_EN
        dbg_next_s = bus.dbg_lock ? ARB_DBG_LOCKED : ARB_PREF_CPU;
`else
        dbg_next_s = ARB_PREF_CPU;
`endif
    end

    // Grant decode and next state; grants are held off while in reset.
    always_comb begin
        cpu_grant_s = 1'b0;
        dbg_grant_s = 1'b0;
        state_d     = state_q;
        if (!rst) begin
            state_d = ARB_PREF_CPU;
        end else begin
            case (state_q)
                ARB_PREF_CPU: begin
                    cpu_grant_s = bus.cpu_req;
                    dbg_grant_s = bus.dbg_req & ~bus.cpu_req;
                end
                ARB_PREF_DBG: begin
                    dbg_grant_s = bus.dbg_req;
                    cpu_grant_s = bus.cpu_req & ~bus.dbg_req;
                end
`ifdef MEM_ARB_LOCK_EN
                ARB_DBG_LOCKED: begin
                    dbg_grant_s = bus.dbg_req;
                end
`endif
                default: begin
                    cpu_grant_s = 1'b0;
                    dbg_grant_s = 1'b0;
                end
            endcase

            if (cpu_grant_s) begin
                state_d = ARB_PREF_DBG;
            end else if (dbg_grant_s) begin
                state_d = dbg_next_s;
            end else begin
                state_d = state_q;
            end
        end
    end

    // Arbiter state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ARB_PREF_CPU;
        end else begin
            state_q <= state_d;
        end
    end

    assign any_grant_s = cpu_grant_s | dbg_grant_s;

    // Winning command mux.
    always_comb begin
        sel_address_s  = bus.cpu_address;
        sel_data_s     = bus.cpu_data;
        sel_write_s    = bus.cpu_writeMode;
        sel_read_s     = bus.cpu_readMode;
        sel_unsigned_s = bus.cpu_unsignedLoad;
        sel_owner_s    = OWNER_CPU;
        if (dbg_grant_s) begin
            sel_address_s  = bus.dbg_address;
            sel_data_s     = bus.dbg_data;
            sel_write_s    = bus.dbg_writeMode;
            sel_read_s     = bus.dbg_readMode;
            sel_unsigned_s = bus.dbg_unsignedLoad;
            sel_owner_s    = OWNER_DBG;
        end else begin
            sel_owner_s    = OWNER_CPU;
        end
    end

    // Memory command next-state: idle cycles keep address/data but issue no access.
    always_comb begin
        mem_address_d  = mem_address_q;
        mem_data_d     = mem_data_q;
        mem_write_d    = ReadWriteMode_NONE;
        mem_read_d     = ReadWriteMode_NONE;
        mem_unsigned_d = mem_unsigned_q;
        if (any_grant_s) begin
            mem_address_d  = sel_address_s;
            mem_data_d     = sel_data_s;
            mem_write_d    = sel_write_s;
            mem_read_d     = sel_read_s;
            mem_unsigned_d = sel_unsigned_s;
        end else begin
            mem_write_d    = ReadWriteMode_NONE;
            mem_read_d     = ReadWriteMode_NONE;
        end
    end

    // Registered command towards Memory.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_address_q  <= {ADDR_W{1'b0}};
            mem_data_q     <= {DATA_W{1'b0}};
            mem_write_q    <= ReadWriteMode_NONE;
            mem_read_q     <= ReadWriteMode_NONE;
            mem_unsigned_q <= 1'b0;
        end else begin
            mem_address_q  <= mem_address_d;
            mem_data_q     <= mem_data_d;
            mem_write_q    <= mem_write_d;
            mem_read_q     <= mem_read_d;
            mem_unsigned_q <= mem_unsigned_d;
        end
    end

    memory_read_tracker u_tracker (
        .clk          (clk),
        .rst          (rst),
        .push_valid_i (any_grant_s && is_read(sel_read_s)),
        .push_owner_i (sel_owner_s),
        .cpu_rvalid_o (cpu_rvalid_s),
        .dbg_rvalid_o (dbg_rvalid_s),
        .rdata_sel_o  (rdata_sel_s)
    );

    assign bus.cpu_grant        = cpu_grant_s;
    assign bus.dbg_grant        = dbg_grant_s;
    assign bus.cpu_rvalid       = cpu_rvalid_s;
    assign bus.dbg_rvalid       = dbg_rvalid_s;
    // Memory data is only forwarded to the owner of the returning read.
    assign bus.cpu_rdata        = (cpu_rvalid_s && rdata_sel_s == OWNER_CPU) ? bus.mem_dataOutput : {DATA_W{1'b0}};
    assign bus.dbg_rdata        = (dbg_rvalid_s && rdata_sel_s == OWNER_DBG) ? bus.mem_dataOutput : {DATA_W{1'b0}};
    assign bus.mem_address      = mem_address_q;
    assign bus.mem_data         = mem_data_q;
    assign bus.mem_writeMode    = mem_write_q;
    assign bus.mem_readMode     = mem_read_q;
    assign bus.mem_unsignedLoad = mem_unsigned_q;

endmodule
